jt7759_rom_bridge: RTL and testbench
====================================

// Module: jt7759_rom_bridge
// PURPOSE
//  ROM-side responder for the jt7759 ADPCM controller. Serves byte requests
//  (rom_cs/rom_addr -> rom_data/rom_ok) from an external 16-bit memory with
//  variable latency (SDRAM/BRAM arbiter, mem_req/mem_ack handshake).
//  Holds a one-word cache, so the paired bytes of a word cost one external
//  access. Supports flush to invalidate the cache on a new sample start.
// PARAMETERS
//  AW    17  byte address width of rom_addr; mem_addr is AW-1 bits (word address)
//  TOUT  255 max cycles waiting for mem_ack before abort (0 = no timeout)
// PORTS
//  rst       in   1     asynchronous reset, active-high
//  clk       in   1     clock
//  flush     in   1     invalidate cache (1-cycle pulse from controller)
//  rom_cs    in   1     request; drops >=1 cycle between consecutive addresses
//  rom_addr  in   AW    byte address
//  rom_data  out  8     byte for rom_addr; valid while rom_ok=1
//  rom_ok    out  1     rom_data valid for current rom_addr
//  mem_req   out  1     external read request, held until mem_ack
//  mem_addr  out  AW-1  word address = rom_addr[AW-1:1], stable while mem_req=1
//  mem_data  in   16    word; byte0 = [7:0] (rom_addr[0]=0), byte1 = [15:8]
//  mem_ack   in   1     1-cycle strobe: mem_data valid, request complete
//  tout_err  out  1     sticky: a fetch timed out; cleared by rst only
// BEHAVIOUR
//  Reset: rom_ok=0, rom_data=0, mem_req=0, mem_addr=0, tout_err=0, cache invalid.
//  Cache: valid bit, tag = word address, 16-bit data.
//  Hit = rom_cs && valid && tag == rom_addr[AW-1:1].
//  FSM IDLE -> FETCH -> IDLE.
//   IDLE: on rom_cs with a hit -> register the byte, ok_r<=1, ok_addr<=rom_addr.
//     rom_ok rises 1 cycle after rom_cs rises.
//     On rom_cs with a miss -> mem_req<=1, mem_addr<=rom_addr[AW-1:1], go to FETCH.
//   FETCH: keep mem_req and mem_addr stable. On mem_ack: mem_req<=0, write cache,
//     valid<=1 unless a flush arrived during FETCH, go to IDLE.
//     The hit check re-runs next cycle, so a miss has rom_ok 2 cycles after mem_ack.
//   Timeout: if TOUT!=0 and the counter reaches TOUT in FETCH: mem_req<=0,
//     tout_err<=1, cache stays invalid, go to IDLE. A pending rom_cs retries.
//  rom_ok output = ok_r && rom_cs && (rom_addr == ok_addr), combinational.
//   It drops in the same cycle that rom_cs falls or the address changes.
//   ok_r clears the cycle after.
//  Abort: rom_cs low or address change during FETCH does not cancel the access.
//   The fetch completes and fills the cache; rom_ok stays 0 until the hit check
//   succeeds for the then-current address.
//  flush: valid<=0 and ok_r<=0 next cycle. flush with a simultaneous mem_ack:
//   the data is discarded (valid=0). flush in IDLE with rom_cs on a cached word:
//   treated as a miss.
//  Address wrap: all-ones word address is legal; there is no prefetch past it.
//  rom_data holds its last value when rom_ok=0.
//  mem_req never re-asserts in the cycle after mem_ack: one IDLE cycle is always
//   spent.
//  Reset mid-FETCH: mem_req drops immediately (async); the memory side must
//   tolerate a dropped request.
// TESTING
//  1. Miss at 0x00005 (mem_data=16'hA55A, ack after 3 cycles) -> one mem_req with
//     mem_addr=0x0002; rom_data=8'hA5; rom_ok 2 cycles after ack.
//  2. Next request 0x00004 after a 1-cycle cs gap -> no mem_req; rom_data=8'h5A;
//     rom_ok 1 cycle after cs.
//  3. Address change 0x00004->0x00006 with cs held -> rom_ok=0 that same cycle;
//     new fetch with mem_addr=0x0003.
//  4. flush coinciding with mem_ack -> cache invalid; re-request of the same
//     address issues a second mem_req.
//  5. TOUT=8, mem_ack never arrives -> mem_req drops after 8 cycles;
//     tout_err=1; rom_ok stays 0.
//  6. rst asserted during FETCH -> all outputs at reset values in the same cycle;
//     the first request after release misses.

Source files
------------

// File: rtl/jt7759_rom_bridge.sv
// ROM-side responder for the jt7759 ADPCM controller: byte reads served from a
// 16-bit variable-latency memory through a one-word cache.
`default_nettype none

module jt7759_rom_bridge #(
  parameter int AW   = 17,
  parameter int TOUT = 255
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          flush,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          rom_ok,
  output logic          mem_req,
  output logic [AW-2:0] mem_addr,
  input  logic [15:0]   mem_data,
  input  logic          mem_ack,
  output logic          tout_err
);

  localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
  localparam logic [CW-1:0] C_TLAST = (TOUT > 0) ? CW'(TOUT - 1) : '0;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [AW-2:0] tag_q, tag_d;
  logic [15:0]   cdata_q, cdata_d;
  logic          ok_q, ok_d;
  logic [AW-1:0] ok_addr_q, ok_addr_d;
  logic [7:0]    data_q, data_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-2:0] mem_addr_q, mem_addr_d;
  logic          tout_err_q, tout_err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flushed_q, flushed_d;

  logic [AW-2:0] w_word;
  logic          w_hit;
  logic          w_tout;

  assign w_word = rom_addr[AW-1:1];
  // A flush in the same cycle wins over a hit on the old cache contents.
  assign w_hit  = rom_cs && valid_q && !flush && (tag_q == w_word);
  assign w_tout = (TOUT != 0) && (state_q == S_FETCH) && !mem_ack && (cnt_q == C_TLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      cdata_q    <= '0;
      ok_q       <= 1'b0;
      ok_addr_q  <= '0;
      data_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      tout_err_q <= 1'b0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      cdata_q    <= cdata_d;
      ok_q       <= ok_d;
      ok_addr_q  <= ok_addr_d;
      data_q     <= data_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      tout_err_q <= tout_err_d;
      cnt_q      <= cnt_d;
      flushed_q  <= flushed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rom_cs && !w_hit) state_d = S_FETCH;
      S_FETCH: if (mem_ack || w_tout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    cdata_d    = cdata_q;
    ok_d       = ok_q;
    ok_addr_d  = ok_addr_q;
    data_d     = data_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    tout_err_d = tout_err_q;
    cnt_d      = cnt_q;
    flushed_d  = flushed_q;
    if (state_q == S_IDLE) begin
      if (flush) valid_d = 1'b0;
      if (w_hit) begin
        ok_d      = 1'b1;
        ok_addr_d = rom_addr;
        data_d    = rom_addr[0] ? cdata_q[15:8] : cdata_q[7:0];
      end else begin
        ok_d = 1'b0;
        if (rom_cs) begin
          // The line is being replaced, so it stays invalid unless the fetch lands.
          valid_d    = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = w_word;
          cnt_d      = '0;
          flushed_d  = 1'b0;
        end
      end
    end else begin
      ok_d = 1'b0;
      if (flush) flushed_d = 1'b1;
      if (mem_ack) begin
        mem_req_d = 1'b0;
        tag_d     = mem_addr_q;
        cdata_d   = mem_data;
        valid_d   = !(flushed_q || flush);
      end else if (w_tout) begin
        mem_req_d  = 1'b0;
        tout_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign rom_ok   = ok_q && rom_cs && (rom_addr == ok_addr_q);
  assign rom_data = data_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign tout_err = tout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_jt7759_rom_bridge.sv
// Directed bench for jt7759_rom_bridge: misses, hits, flush, timeout and async reset.
`default_nettype none

module tb_jt7759_rom_bridge;

  logic        rst, clk, flush, rom_cs, mem_ack;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok, mem_req, tout_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;

  int checks = 0;
  int failures = 0;

  jt7759_rom_bridge #(.AW(17), .TOUT(8)) dut (
    .rst(rst), .clk(clk), .flush(flush), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ack(mem_ack), .tout_err(tout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rom_cs = 1'b0; rom_addr = '0; mem_ack = 1'b0; mem_data = '0;
    step(); step();
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL rst_ok got=%0b exp=0", rom_ok); end
    checks++; if (rom_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", rom_data); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL rst_maddr got=%h exp=0000", mem_addr); end
    checks++; if (tout_err !== 1'b0) begin failures++; $display("FAIL rst_terr got=%0b exp=0", tout_err); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_miss();
    rom_addr = 17'h00005; rom_cs = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL miss_ok_pre got=%0b exp=0", rom_ok); end
    step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL miss_req got=%0b exp=1", mem_req); end
    checks++; if (mem_addr !== 16'h0002) begin failures++; $display("FAIL miss_maddr got=%h exp=0002", mem_addr); end
    step(); step(); step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0002) begin failures++; $display("FAIL miss_hold req=%0b addr=%h exp=1/0002", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 16'hA55A;
    step();
    mem_ack = 1'b0; mem_data = 16'h0000;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL miss_req_drop got=%0b exp=0", mem_req); end
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL miss_ok_early got=%0b exp=0", rom_ok); end
    step();
    checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL miss_ok got=%0b exp=1", rom_ok); end
    checks++; if (rom_data !== 8'hA5) begin failures++; $display("FAIL miss_data got=%h exp=a5", rom_data); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL miss_noreq got=%0b exp=0", mem_req); end
  endtask

  task automatic test_hit();
    rom_cs = 1'b0; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL hit_csdrop got=%0b exp=0", rom_ok); end
    step();
    rom_addr = 17'h00004; rom_cs = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL hit_ok_pre got=%0b exp=0", rom_ok); end
    step();
    checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL hit_ok got=%0b exp=1", rom_ok); end
    checks++; if (rom_data !== 8'h5A) begin failures++; $display("FAIL hit_data got=%h exp=5a", rom_data); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_noreq got=%0b exp=0", mem_req); end
  endtask

  task automatic test_addr_change();
    rom_addr = 17'h00006; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL chg_ok got=%0b exp=0", rom_ok); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0003) begin failures++; $display("FAIL chg_req req=%0b addr=%h exp=1/0003", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 16'h1234;
    step();
    mem_ack = 1'b0;
    step();
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'h34) begin failures++; $display("FAIL chg_data ok=%0b data=%h exp=1/34", rom_ok, rom_data); end
    rom_cs = 1'b0;
    step();
  endtask

  task automatic test_flush_ack();
    rom_addr = 17'h00008; rom_cs = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin failures++; $display("FAIL fl_req1 req=%0b addr=%h exp=1/0004", mem_req, mem_addr); end
    step();
    mem_ack = 1'b1; flush = 1'b1; mem_data = 16'hBEEF;
    step();
    mem_ack = 1'b0; flush = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fl_gap got=%0b exp=0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin failures++; $display("FAIL fl_req2 req=%0b addr=%h exp=1/0004", mem_req, mem_addr); end
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL fl_ok got=%0b exp=0", rom_ok); end
    mem_ack = 1'b1; mem_data = 16'hCAFE;
    step();
    mem_ack = 1'b0;
    step();
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'hFE) begin failures++; $display("FAIL fl_data ok=%0b data=%h exp=1/fe", rom_ok, rom_data); end
    rom_cs = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    rom_addr = 17'h00020; rom_cs = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin failures++; $display("FAIL to_req req=%0b addr=%h exp=1/0010", mem_req, mem_addr); end
    for (int i = 0; i < 7; i++) step();
    checks++; if (mem_req !== 1'b1 || tout_err !== 1'b0) begin failures++; $display("FAIL to_hold req=%0b err=%0b exp=1/0", mem_req, tout_err); end
    step();
    checks++; if (mem_req !== 1'b0 || tout_err !== 1'b1) begin failures++; $display("FAIL to_abort req=%0b err=%0b exp=0/1", mem_req, tout_err); end
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL to_ok got=%0b exp=0", rom_ok); end
    rom_cs = 1'b0;
    step(); step();
    checks++; if (mem_req !== 1'b0 || tout_err !== 1'b1) begin failures++; $display("FAIL to_sticky req=%0b err=%0b exp=0/1", mem_req, tout_err); end
  endtask

  task automatic test_reset_fetch();
    rom_addr = 17'h00008; rom_cs = 1'b1;
    step();
    mem_ack = 1'b1; mem_data = 16'hCAFE;
    step();
    mem_ack = 1'b0;
    step();
    rom_cs = 1'b0;
    step();
    rom_addr = 17'h00009; rom_cs = 1'b1;
    step();
    checks++; if (rom_ok !== 1'b1 || rom_data !== 8'hCA || mem_req !== 1'b0) begin failures++; $display("FAIL rf_hit ok=%0b data=%h req=%0b exp=1/ca/0", rom_ok, rom_data, mem_req); end
    rom_addr = 17'h00040;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020) begin failures++; $display("FAIL rf_req req=%0b addr=%h exp=1/0020", mem_req, mem_addr); end
    #2 rst = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 16'h0 || rom_ok !== 1'b0 || rom_data !== 8'h00 || tout_err !== 1'b0)
      begin failures++; $display("FAIL rf_async req=%0b addr=%h ok=%0b data=%h err=%0b exp=0/0000/0/00/0", mem_req, mem_addr, rom_ok, rom_data, tout_err); end
    rom_cs = 1'b0;
    step();
    rst = 1'b0;
    step();
    rom_addr = 17'h00009; rom_cs = 1'b1; #1;
    checks++; if (rom_ok !== 1'b0) begin failures++; $display("FAIL rf_ok got=%0b exp=0", rom_ok); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0004) begin failures++; $display("FAIL rf_miss req=%0b addr=%h exp=1/0004", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 16'h0000;
    step();
    mem_ack = 1'b0; rom_cs = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_addr_change();
    test_flush_ack();
    test_timeout();
    test_reset_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
